lut_score_argmax: RTL and testbench
===================================

Name: lut_score_argmax

Overview:
- Downstream consumer of the 16-port read-only lookup RAM.
- Each valid beat carries the 16 looked-up values for one prediction candidate. The block sums them in a pipelined adder tree and tracks the running maximum over a frame of candidates.
- At frame end it reports the winning candidate index and its score to the predictor output stage.

Parameters:
- DATAWIDTH, 2, width of each lookup value (must match RAM DATAWIDTH)
- CANDBITS, 2, candidate index width; max candidates per frame NUMCAND = 1 << CANDBITS
- SUMWIDTH, DATAWIDTH+4, score width (sum of 16 unsigned values, overflow impossible)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  val1..val16 hold one candidate's lookups this cycle
- in_last  in  1  qualifies in_valid; this beat is the final candidate of the frame
- val1..val16  in  DATAWIDTH each  unsigned lookup values, aligned with in_valid
- out_valid  out  1  one-cycle pulse; best_idx/best_score updated this cycle
- best_idx  out  CANDBITS  winning candidate index within the frame
- best_score  out  SUMWIDTH  winning candidate's summed score
- busy  out  1  frame open or any pipeline stage holding a valid beat

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, best_idx=0, best_score=0, busy=0.
  - All pipeline valid/first/last tags cleared; candidate counter=0; running best cleared.
  - Reset mid-frame discards the partial frame. No out_valid is produced for it.
- Candidate counter:
  - Assigns index to each accepted beat: 0, 1, 2, ...
  - Resets to 0 after a frame-ending beat.
- Frame end: beat with in_last=1, OR the beat with index NUMCAND-1 (forced last, in_last ignored).
- Idle cycles (in_valid=0) inside a frame are bubbles; the result is unaffected.
- Adder tree (4 registered stages: 16->8->4->2->1):
  - Each stage carries a valid, first, last and index tag.
  - All additions unsigned, zero-extended to SUMWIDTH.
- Compare stage (cycle 5), for a valid beat:
  - If first tag, or sum > running best: running best <= (sum, index).
  - Strict greater-than, so on ties the lower index wins.
- Latency: beat with last tag accepted at edge T -> out_valid=1 in cycle T+5, with best_idx/best_score registered from the frame's final running best.
- Outputs hold their value between pulses. out_valid is high for exactly one cycle per frame.
- Back-to-back frames:
  - The first beat of the next frame may arrive the cycle after the last beat.
  - The first tag reinitialises the running best, so frames do not interact.
  - Minimum spacing between out_valid pulses is 1 cycle (single-beat frames).
- busy:
  - Goes high the cycle after a first beat is accepted.
  - Goes low the cycle after out_valid, unless another beat is in flight or a frame is open.
- No backpressure: the block accepts a beat every cycle.

Test Plan:
- Frame of 4 beats (all vals=1, all=2, twelve=1 plus four=2, all=0 → sums 16,32,20,0), in_last on beat 3, starting edge T0 → out_valid at T0+8, best_idx=1, best_score=32.
- Tie: sums 24,24,10,24 with in_last on beat 3 → best_idx=0, best_score=24.
- Early end: 2 beats, sums 5,7, in_last on beat 1 → best_idx=1, best_score=7. Forced end: 4 beats with in_last never asserted → pulse after beat 3.
- Back-to-back frames with no gap:
  - Frame A: sums 3,9,1,2 → idx1, score 9.
  - Frame B: sums 48,0,0,0 → idx0, score 48.
  - Expect two pulses 4 cycles apart with correct, uncontaminated results.
- Reset after 2 of 4 beats:
  - Expect no out_valid; outputs 0; busy=0 the cycle after reset.
  - New frame (sums 4,6) → idx1, score 6, indices restarting at 0.
- Max values: all vals=3 on every beat with random bubbles between beats → best_score=48, best_idx=0, exactly one out_valid.

Source files
------------

// File: rtl/lut_score_argmax.sv
// Sums 16 lookup values per candidate in a 4-stage adder tree and reports
// the highest-scoring candidate (lowest index on ties) at the end of each frame.
module lut_score_argmax #(
    parameter int DATAWIDTH = 2,
    parameter int CANDBITS  = 2,
    parameter int SUMWIDTH  = DATAWIDTH + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic                 in_last,
    input  logic [DATAWIDTH-1:0] val1,
    input  logic [DATAWIDTH-1:0] val2,
    input  logic [DATAWIDTH-1:0] val3,
    input  logic [DATAWIDTH-1:0] val4,
    input  logic [DATAWIDTH-1:0] val5,
    input  logic [DATAWIDTH-1:0] val6,
    input  logic [DATAWIDTH-1:0] val7,
    input  logic [DATAWIDTH-1:0] val8,
    input  logic [DATAWIDTH-1:0] val9,
    input  logic [DATAWIDTH-1:0] val10,
    input  logic [DATAWIDTH-1:0] val11,
    input  logic [DATAWIDTH-1:0] val12,
    input  logic [DATAWIDTH-1:0] val13,
    input  logic [DATAWIDTH-1:0] val14,
    input  logic [DATAWIDTH-1:0] val15,
    input  logic [DATAWIDTH-1:0] val16,
    output logic                 out_valid,
    output logic [CANDBITS-1:0]  best_idx,
    output logic [SUMWIDTH-1:0]  best_score,
    output logic                 busy
);
    localparam int NUMCAND = 1 << CANDBITS;
    localparam int STAGES  = 4;

    logic [15:0][SUMWIDTH-1:0] v0;
    logic [7:0][SUMWIDTH-1:0]  s1;
    logic [3:0][SUMWIDTH-1:0]  s2;
    logic [1:0][SUMWIDTH-1:0]  s3;
    logic [SUMWIDTH-1:0]       s4;

    logic [STAGES:1]               vld_pipe, fst_pipe, lst_pipe;
    logic [STAGES:1][CANDBITS-1:0] idx_pipe;

    logic [CANDBITS-1:0] cnt;
    logic                beat_first, beat_last;
    logic [CANDBITS-1:0] run_idx;
    logic [SUMWIDTH-1:0] run_score;
    logic                pend;

    assign v0[0]  = SUMWIDTH'(val1);
    assign v0[1]  = SUMWIDTH'(val2);
    assign v0[2]  = SUMWIDTH'(val3);
    assign v0[3]  = SUMWIDTH'(val4);
    assign v0[4]  = SUMWIDTH'(val5);
    assign v0[5]  = SUMWIDTH'(val6);
    assign v0[6]  = SUMWIDTH'(val7);
    assign v0[7]  = SUMWIDTH'(val8);
    assign v0[8]  = SUMWIDTH'(val9);
    assign v0[9]  = SUMWIDTH'(val10);
    assign v0[10] = SUMWIDTH'(val11);
    assign v0[11] = SUMWIDTH'(val12);
    assign v0[12] = SUMWIDTH'(val13);
    assign v0[13] = SUMWIDTH'(val14);
    assign v0[14] = SUMWIDTH'(val15);
    assign v0[15] = SUMWIDTH'(val16);

    // The last slot of a frame closes it even without in_last.
    assign beat_first = (cnt == '0);
    assign beat_last  = in_last || (cnt == CANDBITS'(NUMCAND - 1));

    // Sum datapath carries no reset; only the tags decide what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 8; i++) s1[i] <= v0[2*i] + v0[2*i+1];
        for (int i = 0; i < 4; i++) s2[i] <= s1[2*i] + s1[2*i+1];
        for (int i = 0; i < 2; i++) s3[i] <= s2[2*i] + s2[2*i+1];
        s4 <= s3[0] + s3[1];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            fst_pipe <= '0;
            lst_pipe <= '0;
            idx_pipe <= '0;
            cnt      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
            fst_pipe <= {fst_pipe[STAGES-1:1], in_valid & beat_first};
            lst_pipe <= {lst_pipe[STAGES-1:1], in_valid & beat_last};
            idx_pipe <= {idx_pipe[STAGES-1:1], cnt};
            if (in_valid)
                cnt <= beat_last ? '0 : cnt + CANDBITS'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            run_idx    <= '0;
            run_score  <= '0;
            pend       <= 1'b0;
            out_valid  <= 1'b0;
            best_idx   <= '0;
            best_score <= '0;
        end else begin
            pend <= vld_pipe[STAGES] & lst_pipe[STAGES];
            // Strict compare keeps the earlier index on ties.
            if (vld_pipe[STAGES] && (fst_pipe[STAGES] || s4 > run_score)) begin
                run_idx   <= idx_pipe[STAGES];
                run_score <= s4;
            end
            out_valid <= pend;
            if (pend) begin
                best_idx   <= run_idx;
                best_score <= run_score;
            end
        end
    end

    assign busy = (cnt != '0) | (|vld_pipe) | pend | out_valid;

endmodule

// File: tb/tb_lut_score_argmax.sv
// Randomized scoreboard bench for lut_score_argmax: a frame-level argmax model
// predicts each result and the cycle it should appear in.
module tb_lut_score_argmax;
    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_last;
    logic [1:0] vv [16];
    logic       out_valid;
    logic [1:0] best_idx;
    logic [5:0] best_score;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { int idx; int score; int cyc; } exp_t;
    exp_t sbq[$];
    int   m_sums[$];

    lut_score_argmax dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last),
        .val1(vv[0]),   .val2(vv[1]),   .val3(vv[2]),   .val4(vv[3]),
        .val5(vv[4]),   .val6(vv[5]),   .val7(vv[6]),   .val8(vv[7]),
        .val9(vv[8]),   .val10(vv[9]),  .val11(vv[10]), .val12(vv[11]),
        .val13(vv[12]), .val14(vv[13]), .val15(vv[14]), .val16(vv[15]),
        .out_valid(out_valid), .best_idx(best_idx), .best_score(best_score),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Spread a target sum randomly over the 16 lanes (each 0..3).
    task automatic fill(input int s);
        int rem, k;
        for (int i = 0; i < 16; i++) vv[i] = 2'd0;
        rem = s;
        while (rem > 0) begin
            k = $urandom_range(15);
            if (vv[k] != 2'd3) begin
                vv[k] = vv[k] + 2'd1;
                rem--;
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called #1 after an edge; the beat is accepted at the next edge.
    task automatic beat(input int s, input bit last);
        int acc, bi;
        fill(s);
        in_valid = 1'b1;
        in_last  = last;
        acc = cyc + 1;
        m_sums.push_back(s);
        if (last || m_sums.size() == 4) begin
            bi = 0;
            for (int i = 1; i < m_sums.size(); i++)
                if (m_sums[i] > m_sums[bi]) bi = i;
            sbq.push_back('{idx: bi, score: m_sums[bi], cyc: acc + 5});
            m_sums.delete();
        end
        step(1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_out_valid", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("best_idx", int'(best_idx), e.idx);
                chk("best_score", int'(best_score), e.score);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int len, t;
        bit lst;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 16; i++) vv[i] = 2'd0;
        step(3);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_best_idx", int'(best_idx), 0);
        chk("rst_best_score", int'(best_score), 0);
        chk("rst_busy", int'(busy), 0);
        rst = 1'b0;
        step(2);

        // basic frame, busy rises after the first beat
        beat(16, 0);
        chk("busy_after_first", int'(busy), 1);
        beat(32, 0); beat(20, 0); beat(0, 1);
        step(8);
        // tie keeps the lowest index
        beat(24, 0); beat(24, 0); beat(10, 0); beat(24, 1);
        step(8);
        // early end, then forced end
        beat(5, 0); beat(7, 1);
        step(8);
        beat(1, 0); beat(2, 0); beat(3, 0); beat(2, 0);
        beat(9, 1);
        step(8);
        // back-to-back frames
        beat(3, 0); beat(9, 0); beat(1, 0); beat(2, 1);
        beat(48, 0); beat(0, 0); beat(0, 0); beat(0, 1);
        // single-beat frames at full rate
        beat(11, 1); beat(12, 1); beat(5, 1);
        step(10);
        chk("busy_idle", int'(busy), 0);

        // reset discards a partial frame
        beat(10, 0); beat(20, 0);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        m_sums.delete();
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_best_idx", int'(best_idx), 0);
        chk("midrst_best_score", int'(best_score), 0);
        chk("midrst_busy", int'(busy), 0);
        step(8);
        beat(4, 0); beat(6, 1);
        step(8);

        // max values with bubbles, forced end
        for (int b = 0; b < 4; b++) begin
            beat(48, 0);
            step($urandom_range(3));
        end
        step(8);

        // random frames
        for (int f = 0; f < 40; f++) begin
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                lst = (b == len - 1) ? ((len < 4) ? 1'b1 : 1'($urandom_range(1))) : 1'b0;
                beat($urandom_range(48), lst);
                if ($urandom_range(3) == 0) step($urandom_range(1, 2));
            end
        end

        t = 0;
        while (sbq.size() > 0 && t < 100) begin
            step(1);
            t++;
        end
        chk("drain_pending", sbq.size(), 0);
        step(3);
        chk("busy_end", int'(busy), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
